// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory request arbiter: FSM state encoding,
// ID-table entry layout and the effective outstanding-transaction cap.
package mem_arb_pkg;

   // Wide enough to name up to 16 requesters in the ID table.
   localparam int unsigned SrcWidth = 4;

   typedef enum logic [1:0] {
      RUN,
      NC_DRAIN,
      NC_WAIT
   } arb_state_e;

   typedef struct packed {
      logic                busy;
      logic [SrcWidth-1:0] src;
   } tid_entry_t;

   function automatic int unsigned eff_cap(input int unsigned max_out, input int unsigned tid_w);
      int unsigned n_ids;
      n_ids = 32'd1 << tid_w;
      return (max_out < n_ids) ? max_out : n_ids;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping around; the pointer moves past the winner only when advance_i is set.
module rr_arbiter #(
   parameter int unsigned NrReq = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [NrReq-1:0] req_i,
   input  logic             advance_i,
   output logic [NrReq-1:0] grant_o
);

   localparam int unsigned PtrWidth = (NrReq > 1) ? $clog2(NrReq) : 1;

   logic [PtrWidth-1:0] ptr_q, ptr_d, win_idx;
   logic [NrReq-1:0]    upper_mask, upper_req, pick;

   for (genvar gi = 0; gi < NrReq; gi++) begin : g_mask
      assign upper_mask[gi] = (ptr_q <= PtrWidth'(gi));
   end

   // Prefer requesters at/after the pointer, then isolate the lowest set bit.
   assign upper_req = req_i & upper_mask;
   assign pick      = (|upper_req) ? upper_req : req_i;
   assign grant_o   = pick & (~pick + NrReq'(1));

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NrReq; i++) begin
         if (grant_o[i]) win_idx = PtrWidth'(i);
      end
      ptr_d = ptr_q;
      if (advance_i) begin
         ptr_d = (win_idx == PtrWidth'(NrReq - 1)) ? '0 : win_idx + PtrWidth'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mem_req_arb.sv
// Arbitrates requesters onto one memory port with transaction-ID allocation and
// non-idempotent serialisation. MEM_REQ_ARB_PERF_EN adds stall/nc counters.
module mem_req_arb
   import mem_arb_pkg::*;
#(
   parameter int unsigned NrReq          = 3,
   parameter int unsigned TidWidth       = 2,
   parameter int unsigned MaxOutstanding = 7,
   parameter int unsigned AddrWidth      = 64,
   parameter int unsigned DataWidth      = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NrReq-1:0]           req_valid_i,
   output logic [NrReq-1:0]           req_ready_o,
   input  logic [NrReq-1:0]           req_we_i,
   input  logic [NrReq-1:0]           req_nc_i,
   input  logic [NrReq*AddrWidth-1:0] req_addr_i,
   input  logic [NrReq*DataWidth-1:0] req_wdata_i,
   output logic                       mem_valid_o,
   input  logic                       mem_ready_i,
   output logic [AddrWidth-1:0]       mem_addr_o,
   output logic [DataWidth-1:0]       mem_wdata_o,
   output logic                       mem_we_o,
   output logic [TidWidth-1:0]        mem_tid_o,
   input  logic                       rsp_valid_i,
   input  logic [TidWidth-1:0]        rsp_tid_i,
   output logic [NrReq-1:0]           rsp_valid_o,
   output logic [TidWidth:0]          outstanding_o,
   output logic                       idle_o,
   output logic                       tid_err_o
`ifdef MEM_REQ_ARB_PERF_EN
   ,
   output logic [31:0]                stall_cnt_o,
   output logic [15:0]                nc_cnt_o
`endif
);

   localparam int unsigned       NumTid = 1 << TidWidth;
   localparam logic [TidWidth:0] CapCnt = (TidWidth+1)'(eff_cap(MaxOutstanding, TidWidth));
   localparam logic [TidWidth:0] CntOne = (TidWidth+1)'(1);

   arb_state_e            state_q, state_d;
   tid_entry_t            tid_tab_q [NumTid];
   logic [TidWidth:0]     outstanding_q, outstanding_d;
   logic                  mem_valid_q, mem_we_q, tid_err_q;
   logic [AddrWidth-1:0]  mem_addr_q;
   logic [DataWidth-1:0]  mem_wdata_q;
   logic [TidWidth-1:0]   mem_tid_q, alloc_tid;
   logic [NrReq-1:0]      grant;
   logic                  capture, capture_ok, win_nc, win_we, free_found, rsp_hit;
   logic [SrcWidth-1:0]   win_src;
   logic [AddrWidth-1:0]  win_addr;
   logic [DataWidth-1:0]  win_wdata;

   rr_arbiter #(.NrReq(NrReq)) u_rr (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (req_valid_i),
      .advance_i (capture),
      .grant_o   (grant)
   );

   assign capture_ok = !mem_valid_q || mem_ready_i;
   assign win_nc     = |(grant & req_nc_i);
   assign win_we     = |(grant & req_we_i);
   assign rsp_hit    = rsp_valid_i && tid_tab_q[rsp_tid_i].busy;

   always_comb begin
      win_src   = '0;
      win_addr  = '0;
      win_wdata = '0;
      for (int i = 0; i < NrReq; i++) begin
         if (grant[i]) begin
            win_src   = SrcWidth'(i);
            win_addr  = req_addr_i[i*AddrWidth +: AddrWidth];
            win_wdata = req_wdata_i[i*DataWidth +: DataWidth];
         end
      end
      // Descending scan so the lowest free ID wins; uses the registered busy bits.
      free_found = 1'b0;
      alloc_tid  = '0;
      for (int i = int'(NumTid) - 1; i >= 0; i--) begin
         if (!tid_tab_q[i].busy) begin
            free_found = 1'b1;
            alloc_tid  = TidWidth'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         RUN: begin
            if (|grant) begin
               if (win_nc) begin
                  if (outstanding_q != '0) begin
                     state_d = NC_DRAIN;
                  end else if (capture_ok) begin
                     capture = 1'b1;
                     state_d = NC_WAIT;
                  end
               end else if (free_found && (outstanding_q < CapCnt) && capture_ok) begin
                  capture = 1'b1;
               end
            end
         end
         NC_DRAIN: begin
            if (!((|grant) && win_nc)) begin
               state_d = RUN;
            end else if ((outstanding_q == '0) && capture_ok) begin
               capture = 1'b1;
               state_d = NC_WAIT;
            end
         end
         // Only the nc ID can be allocated here, so any valid hit is its response.
         NC_WAIT: begin
            if (rsp_hit) state_d = RUN;
         end
         default: state_d = RUN;
      endcase

      outstanding_d = outstanding_q;
      if (capture && !rsp_hit)      outstanding_d = outstanding_q + CntOne;
      else if (!capture && rsp_hit) outstanding_d = outstanding_q - CntOne;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= RUN;
         outstanding_q <= '0;
         mem_valid_q   <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_we_q      <= 1'b0;
         mem_tid_q     <= '0;
         tid_err_q     <= 1'b0;
         for (int i = 0; i < NumTid; i++) tid_tab_q[i] <= '0;
      end else begin
         state_q       <= state_d;
         outstanding_q <= outstanding_d;
         if (capture) begin
            mem_valid_q          <= 1'b1;
            mem_addr_q           <= win_addr;
            mem_wdata_q          <= win_wdata;
            mem_we_q             <= win_we;
            mem_tid_q            <= alloc_tid;
            tid_tab_q[alloc_tid] <= '{busy: 1'b1, src: win_src};
         end else if (mem_ready_i) begin
            mem_valid_q <= 1'b0;
         end
         if (rsp_hit) tid_tab_q[rsp_tid_i].busy <= 1'b0;
         if (rsp_valid_i && !rsp_hit) tid_err_q <= 1'b1;
      end
   end

   for (genvar gi = 0; gi < NrReq; gi++) begin : g_rsp
      assign rsp_valid_o[gi] = rsp_hit && (tid_tab_q[rsp_tid_i].src == SrcWidth'(gi));
   end

   assign req_ready_o   = capture ? grant : '0;
   assign mem_valid_o   = mem_valid_q;
   assign mem_addr_o    = mem_addr_q;
   assign mem_wdata_o   = mem_wdata_q;
   assign mem_we_o      = mem_we_q;
   assign mem_tid_o     = mem_tid_q;
   assign outstanding_o = outstanding_q;
   assign idle_o        = (outstanding_q == '0) && !mem_valid_q;
   assign tid_err_o     = tid_err_q;

`ifdef MEM_REQ_ARB_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [15:0] nc_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
         nc_cnt_q    <= '0;
      end else begin
         if ((|req_valid_i) && !capture) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (capture && win_nc && (nc_cnt_q != 16'hFFFF)) nc_cnt_q <= nc_cnt_q + 16'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign nc_cnt_o    = nc_cnt_q;
`endif

endmodule

// File: tb/tb_mem_req_arb.sv
// Directed scoreboard bench for mem_req_arb: stimulus pushes expected memory
// issues and routed responses; a monitor pops them as the DUT presents them.
module tb_mem_req_arb;

   logic          clk;
   logic          rst_i;
   logic [2:0]    req_valid_i, req_ready_o, req_we_i, req_nc_i, rsp_valid_o;
   logic [191:0]  req_addr_i, req_wdata_i;
   logic          mem_valid_o, mem_ready_i, mem_we_o, rsp_valid_i, idle_o, tid_err_o;
   logic [63:0]   mem_addr_o, mem_wdata_o;
   logic [1:0]    mem_tid_o, rsp_tid_i;
   logic [2:0]    outstanding_o;
`ifdef MEM_REQ_ARB_PERF_EN
   logic [31:0]   stall_cnt_o;
   logic [15:0]   nc_cnt_o;
`endif

   typedef struct {
      logic [63:0] addr;
      logic [63:0] wdata;
      logic        we;
      logic [1:0]  tid;
   } mem_exp_t;

   mem_exp_t    mem_q[$];
   logic [2:0]  rsp_q[$];
   logic [63:0] addr_tab [3];
   logic [63:0] data_tab [3];
   int          checks = 0;
   int          errors = 0;

   mem_req_arb #(
      .NrReq(3), .TidWidth(2), .MaxOutstanding(7), .AddrWidth(64), .DataWidth(64)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_we_i      (req_we_i),
      .req_nc_i      (req_nc_i),
      .req_addr_i    (req_addr_i),
      .req_wdata_i   (req_wdata_i),
      .mem_valid_o   (mem_valid_o),
      .mem_ready_i   (mem_ready_i),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_we_o      (mem_we_o),
      .mem_tid_o     (mem_tid_o),
      .rsp_valid_i   (rsp_valid_i),
      .rsp_tid_i     (rsp_tid_i),
      .rsp_valid_o   (rsp_valid_o),
      .outstanding_o (outstanding_o),
      .idle_o        (idle_o),
      .tid_err_o     (tid_err_o)
`ifdef MEM_REQ_ARB_PERF_EN
      ,
      .stall_cnt_o   (stall_cnt_o),
      .nc_cnt_o      (nc_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_mem(input int src, input int tid);
      mem_exp_t e;
      e.addr  = addr_tab[src];
      e.wdata = data_tab[src];
      e.we    = (src == 2);
      e.tid   = 2'(tid);
      mem_q.push_back(e);
   endtask

   task automatic rdy(input string name, input logic [2:0] exp);
      @(negedge clk);
      check(name, 64'(req_ready_o), 64'(exp));
   endtask

   // Monitor: pops expectations whenever the DUT presents an issue or a response.
   initial begin
      mem_exp_t e;
      logic [2:0] r;
      @(negedge rst_i);
      forever begin
         @(negedge clk);
         if (mem_valid_o && mem_ready_i) begin
            if (mem_q.size() == 0) begin
               check("mem_unexpected_issue", 64'(mem_tid_o), 64'hFFFF);
            end else begin
               e = mem_q.pop_front();
               check("mem_addr", mem_addr_o, e.addr);
               check("mem_wdata", mem_wdata_o, e.wdata);
               check("mem_we", 64'(mem_we_o), 64'(e.we));
               check("mem_tid", 64'(mem_tid_o), 64'(e.tid));
            end
         end
         if (|rsp_valid_o) begin
            if (rsp_q.size() == 0) begin
               check("rsp_unexpected", 64'(rsp_valid_o), 64'h0);
            end else begin
               r = rsp_q.pop_front();
               check("rsp_route", 64'(rsp_valid_o), 64'(r));
            end
         end
      end
   end

   initial begin
      int gorder [4] = '{0, 1, 2, 0};
      int srcs   [4] = '{0, 1, 2, 0};
      addr_tab = '{64'h0000_0000_0000_1000, 64'h0000_0000_0000_2000, 64'h0000_0000_0000_3000};
      data_tab = '{64'hD0D0_0000_0000_0000, 64'hD1D1_0000_0000_0001, 64'hD2D2_0000_0000_0002};
      rst_i = 1'b1; req_valid_i = '0; req_we_i = 3'b100; req_nc_i = '0;
      req_addr_i  = {addr_tab[2], addr_tab[1], addr_tab[0]};
      req_wdata_i = {data_tab[2], data_tab[1], data_tab[0]};
      mem_ready_i = 1'b1; rsp_valid_i = 1'b0; rsp_tid_i = '0;

      tick(); tick();
      @(negedge clk);
      check("rst_mem_valid", 64'(mem_valid_o), 64'h0);
      check("rst_req_ready", 64'(req_ready_o), 64'h0);
      check("rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
      check("rst_outstanding", 64'(outstanding_o), 64'h0);
      check("rst_idle", 64'(idle_o), 64'h1);
      check("rst_tid_err", 64'(tid_err_o), 64'h0);
      check("rst_mem_tid", 64'(mem_tid_o), 64'h0);

      // All requesters, round-robin 0,1,2,0 with tids 0..3, then no free ID.
      tick(); rst_i = 1'b0; req_valid_i = 3'b111;
      for (int k = 0; k < 4; k++) push_mem(gorder[k], k);
      for (int k = 0; k < 4; k++) begin
         rdy("rr_grant", 3'b001 << gorder[k]);
         tick();
      end
      @(negedge clk);
      check("full_ready", 64'(req_ready_o), 64'h0);
      check("full_outstanding", 64'(outstanding_o), 64'h4);

      // Free tid1: routed to requester 1, reallocated only in the next cycle.
      tick(); rsp_valid_i = 1'b1; rsp_tid_i = 2'd1; rsp_q.push_back(3'b010);
      @(negedge clk);
      check("free_same_cycle_ready", 64'(req_ready_o), 64'h0);
      check("free_same_cycle_out", 64'(outstanding_o), 64'h4);
      tick(); rsp_tid_i = 2'd2; rsp_q.push_back(3'b100); push_mem(1, 1);
      rdy("realloc_tid1", 3'b010);
      check("realloc_out", 64'(outstanding_o), 64'h3);
      tick(); rsp_valid_i = 1'b0; push_mem(2, 2);
      rdy("realloc_tid2", 3'b100);
      check("alloc_free_same_cycle_out", 64'(outstanding_o), 64'h3);
      tick(); req_valid_i = 3'b000;
      @(negedge clk);
      check("refill_out", 64'(outstanding_o), 64'h4);
      for (int k = 0; k < 4; k++) begin
         tick(); rsp_valid_i = 1'b1; rsp_tid_i = 2'(k); rsp_q.push_back(3'b001 << srcs[k]);
         @(negedge clk);
      end
      tick(); rsp_valid_i = 1'b0;
      @(negedge clk);
      check("drain_out", 64'(outstanding_o), 64'h0);
      check("drain_idle", 64'(idle_o), 64'h1);

      // Non-idempotent access from requester 2 behind two outstanding IDs.
      tick(); req_valid_i = 3'b001; push_mem(0, 0);
      rdy("nc_pre0", 3'b001);
      tick(); req_valid_i = 3'b010; push_mem(1, 1);
      rdy("nc_pre1", 3'b010);
      tick(); req_valid_i = 3'b101; req_nc_i = 3'b100;
      for (int k = 0; k < 3; k++) begin
         rdy("nc_drain_no_bypass", 3'b000);
         tick();
      end
      rsp_valid_i = 1'b1; rsp_tid_i = 2'd0; rsp_q.push_back(3'b001);
      rdy("nc_drain_rsp0", 3'b000);
      tick(); rsp_tid_i = 2'd1; rsp_q.push_back(3'b010);
      rdy("nc_drain_rsp1", 3'b000);
      tick(); rsp_valid_i = 1'b0; push_mem(2, 0);
      rdy("nc_issue", 3'b100);
      tick(); req_valid_i = 3'b001; req_nc_i = 3'b000;
      rdy("nc_wait_block", 3'b000);
      check("nc_wait_out", 64'(outstanding_o), 64'h1);
      tick();
      rdy("nc_wait_block2", 3'b000);
      tick(); rsp_valid_i = 1'b1; rsp_tid_i = 2'd0; rsp_q.push_back(3'b100);
      rdy("nc_rsp_cycle", 3'b000);
      tick(); rsp_valid_i = 1'b0; mem_ready_i = 1'b0; push_mem(0, 0);
      rdy("nc_after_run", 3'b001);

      // Back-pressure: output fields frozen and no acceptance.
      for (int k = 0; k < 5; k++) begin
         tick();
         @(negedge clk);
         check("bp_valid", 64'(mem_valid_o), 64'h1);
         check("bp_addr", mem_addr_o, addr_tab[0]);
         check("bp_tid", 64'(mem_tid_o), 64'h0);
         check("bp_we", 64'(mem_we_o), 64'h0);
         check("bp_ready", 64'(req_ready_o), 64'h0);
      end
      tick(); mem_ready_i = 1'b1; push_mem(0, 1);
      rdy("bp_release_b2b", 3'b001);
      tick(); req_valid_i = 3'b000;
      @(negedge clk);
      check("bp_out", 64'(outstanding_o), 64'h2);

      // Unallocated response ID.
      tick(); rsp_valid_i = 1'b1; rsp_tid_i = 2'd3;
      @(negedge clk);
      check("bad_tid_rsp", 64'(rsp_valid_o), 64'h0);
      tick(); rsp_valid_i = 1'b0;
      @(negedge clk);
      check("bad_tid_err", 64'(tid_err_o), 64'h1);
      tick();
      @(negedge clk);
      check("bad_tid_sticky", 64'(tid_err_o), 64'h1);

      // Reset with three IDs outstanding, then a late response.
      tick(); req_valid_i = 3'b010; push_mem(1, 2);
      rdy("pre_rst_grant", 3'b010);
      tick(); req_valid_i = 3'b000; rst_i = 1'b1;
      @(negedge clk);
      check("pre_rst_out", 64'(outstanding_o), 64'h3);
      tick(); rst_i = 1'b0;
      @(negedge clk);
      check("post_rst_out", 64'(outstanding_o), 64'h0);
      check("post_rst_idle", 64'(idle_o), 64'h1);
      check("post_rst_valid", 64'(mem_valid_o), 64'h0);
      check("post_rst_err", 64'(tid_err_o), 64'h0);
      tick(); rsp_valid_i = 1'b1; rsp_tid_i = 2'd0;
      @(negedge clk);
      check("late_rsp_drop", 64'(rsp_valid_o), 64'h0);
      tick(); rsp_valid_i = 1'b0;
      @(negedge clk);
      check("late_rsp_err", 64'(tid_err_o), 64'h1);

      tick();
      check("mem_queue_empty", 64'(mem_q.size()), 64'h0);
      check("rsp_queue_empty", 64'(rsp_q.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
